decode_pipe: RTL and testbench

DECODE_PIPE -- requirements
Module: decode_pipe

---
 rtl/decode_pipe.sv | 170 +++++++++++++++++
 tb/tb_decode_pipe.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_pipe.sv
// decode_pipe -- instruction decode stage with a 2-entry elastic buffer.
//
// Decodes a 32-bit instruction word combinationally when it is accepted and
// stores the decoded record. The record sits either in the output entry,
// which drives the outputs, or in the skid entry. The skid entry absorbs one
// extra instruction while the consumer stalls. This keeps in_ready a flop
// and still allows one instruction per cycle.
//
// Build option: define DECODE_ROT_IMM_EN to enable the data-processing
// immediate rotator (instr[7:0] rotated right by 2*instr[11:8]). When it is
// not defined, the data-processing immediate is zero-extended instr[7:0].
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   flush                    synchronous discard of buffered/incoming instrs
//   in_valid, in_ready       upstream handshake (in_ready is registered)
//   instr[31:0]              fetched instruction word
//   out_valid, out_ready     downstream handshake
//   use_mem, r_w, is_branch, illegal, cond, funct, rd, rn, rm, imm
//                            decoded fields of the output entry
module decode_pipe #(
  parameter int REG_W = 4,
  parameter int IMM_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             use_mem,
  output logic             r_w,
  output logic             is_branch,
  output logic             illegal,
  output logic [3:0]       cond,
  output logic [3:0]       funct,
  output logic [REG_W-1:0] rd,
  output logic [REG_W-1:0] rn,
  output logic [REG_W-1:0] rm,
  output logic [IMM_W-1:0] imm
);

  typedef struct packed {
    logic             use_mem;
    logic             r_w;
    logic             is_branch;
    logic             illegal;
    logic [3:0]       cond;
    logic [3:0]       funct;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rn;
    logic [REG_W-1:0] rm;
    logic [IMM_W-1:0] imm;
  } rec_t;

  rec_t             dec;
  logic [IMM_W-1:0] dp_imm;

`ifdef DECODE_ROT_IMM_EN
  logic [31:0] imm8;
  logic [5:0]  rot_amt;
  assign imm8    = {24'd0, instr[7:0]};
  assign rot_amt = {1'b0, instr[11:8], 1'b0};
  // A left shift by 32 (rot_amt == 0) gives zero, so a zero rotate still
  // returns imm8 without any special case.
  assign dp_imm  = IMM_W'((imm8 >> rot_amt) | (imm8 << (6'd32 - rot_amt)));
`else
  assign dp_imm  = IMM_W'(instr[7:0]);
`endif

  always_comb begin
    dec      = '0;
    dec.cond = instr[31:28];
    case (instr[27:26])
      2'b00: begin
        dec.funct = instr[24:21];
        dec.rn    = REG_W'(instr[19:16]);
        dec.rd    = REG_W'(instr[15:12]);
        if (instr[25]) dec.imm = dp_imm;
        else           dec.rm  = REG_W'(instr[3:0]);
      end
      2'b01: begin
        dec.use_mem = 1'b1;
        dec.r_w     = !instr[20];
        dec.funct   = instr[24:21];
        dec.rn      = REG_W'(instr[19:16]);
        dec.rd      = REG_W'(instr[15:12]);
        // For memory ops, bit 25 selects the register offset, so its meaning
        // is the inverse of the data-processing case.
        if (!instr[25]) dec.imm = IMM_W'(instr[11:0]);
        else            dec.rm  = REG_W'(instr[3:0]);
      end
      2'b10: begin
        dec.is_branch = 1'b1;
        dec.imm       = IMM_W'($signed({instr[23:0], 2'b00}));
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  rec_t e0_q, e1_q, e0_n, e1_n;
  logic v0_q, v1_q, v0_n, v1_n;
  logic rdy_q;
  logic acc, xfer;

  assign acc  = in_valid && rdy_q;
  assign xfer = v0_q && out_ready;

  // The skid entry can hold a record only while the output entry is valid.
  // Flush takes priority over both accept and transfer.
  always_comb begin
    e0_n = e0_q;
    e1_n = e1_q;
    v0_n = v0_q;
    v1_n = v1_q;
    if (flush) begin
      v0_n = 1'b0;
      v1_n = 1'b0;
    end else if (!v0_q) begin
      if (acc) begin
        e0_n = dec;
        v0_n = 1'b1;
      end
    end else if (!v1_q) begin
      if (xfer && acc) begin
        e0_n = dec;
      end else if (xfer) begin
        v0_n = 1'b0;
      end else if (acc) begin
        e1_n = dec;
        v1_n = 1'b1;
      end
    end else if (xfer) begin
      e0_n = e1_q;
      v1_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e0_q  <= '0;
      e1_q  <= '0;
      v0_q  <= 1'b0;
      v1_q  <= 1'b0;
      rdy_q <= 1'b1;
    end else begin
      e0_q  <= e0_n;
      e1_q  <= e1_n;
      v0_q  <= v0_n;
      v1_q  <= v1_n;
      rdy_q <= !v1_n;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = v0_q;
  assign use_mem   = e0_q.use_mem;
  assign r_w       = e0_q.r_w;
  assign is_branch = e0_q.is_branch;
  assign illegal   = e0_q.illegal;
  assign cond      = e0_q.cond;
  assign funct     = e0_q.funct;
  assign rd        = e0_q.rd;
  assign rn        = e0_q.rn;
  assign rm        = e0_q.rm;
  assign imm       = e0_q.imm;

endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe -- scoreboard bench for decode_pipe.
// The driver pushes the hand-computed decoded record when an instruction is
// accepted. A separate monitor pops that record and compares it on every
// output transfer. The monitor also checks that outputs hold steady while
// they are stalled.
module tb_decode_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        use_mem, r_w, is_branch, illegal;
  logic [3:0]  cond, funct, rd, rn, rm;
  logic [31:0] imm;

  typedef struct packed {
    logic        use_mem;
    logic        r_w;
    logic        is_branch;
    logic        illegal;
    logic [3:0]  cond;
    logic [3:0]  funct;
    logic [3:0]  rd;
    logic [3:0]  rn;
    logic [3:0]  rm;
    logic [31:0] imm;
  } rec_t;

  rec_t q[$];
  int   errors = 0;
  int   checks = 0;

`ifdef DECODE_ROT_IMM_EN
  localparam logic [31:0] IMM_V2 = 32'hFF00_0000;
  localparam logic [31:0] IMM_V9 = 32'h8000_0000;
`else
  localparam logic [31:0] IMM_V2 = 32'h0000_00FF;
  localparam logic [31:0] IMM_V9 = 32'h0000_0002;
`endif

  always #5 clk = ~clk;

  decode_pipe #(.REG_W(4), .IMM_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .use_mem(use_mem), .r_w(r_w), .is_branch(is_branch), .illegal(illegal),
    .cond(cond), .funct(funct), .rd(rd), .rn(rn), .rm(rm), .imm(imm)
  );

  function automatic rec_t mk(input logic um, input logic rw, input logic br,
                              input logic il, input logic [3:0] c,
                              input logic [3:0] f, input logic [3:0] d,
                              input logic [3:0] n, input logic [3:0] m,
                              input logic [31:0] i);
    rec_t r;
    r = '{use_mem: um, r_w: rw, is_branch: br, illegal: il, cond: c,
          funct: f, rd: d, rn: n, rm: m, imm: i};
    return r;
  endfunction

  function automatic rec_t got_rec();
    rec_t r;
    r = '{use_mem: use_mem, r_w: r_w, is_branch: is_branch, illegal: illegal,
          cond: cond, funct: funct, rd: rd, rn: rn, rm: rm, imm: imm};
    return r;
  endfunction

  task automatic check1(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_rec(input string name, input rec_t act, input rec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  rec_t held_rec;
  logic held = 1'b0;
  always @(negedge clk) begin
    rec_t e;
    if (rst) begin
      if (out_valid && held) check_rec("stall_stable", got_rec(), held_rec);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %h expected none", got_rec());
        end else begin
          e = q.pop_front();
          check_rec("output", got_rec(), e);
        end
      end
      held     = out_valid && !out_ready;
      held_rec = got_rec();
    end else begin
      held = 1'b0;
    end
  end

  task automatic send(input logic [31:0] w, input rec_t e);
    int n = 0;
    in_valid = 1'b1;
    instr    = w;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end else begin
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (q.size() != 0 && n < 50) begin
      n++;
      @(negedge clk);
    end
    check1("drain_empty", 64'(q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] V1  = 32'hE281_0005;
  localparam logic [31:0] V2  = 32'hE3A0_04FF;
  localparam logic [31:0] V3  = 32'hEAFF_FFFE;
  localparam logic [31:0] V4  = 32'hE591_0004;
  localparam logic [31:0] V5  = 32'hE082_1003;
  localparam logic [31:0] V6  = 32'hE781_2003;
  localparam logic [31:0] V7  = 32'h5C12_3456;
  localparam logic [31:0] V8  = 32'h0A00_0010;
  localparam logic [31:0] V9  = 32'hE3A0_1102;
  localparam logic [31:0] V10 = 32'hE582_1FFF;

  rec_t r1, r2, r3, r4, r5, r6, r7, r8, r9, r10;

  initial begin
    r1  = mk(0, 0, 0, 0, 4'hE, 4'h4, 4'h0, 4'h1, 4'h0, 32'h5);
    r2  = mk(0, 0, 0, 0, 4'hE, 4'hD, 4'h0, 4'h0, 4'h0, IMM_V2);
    r3  = mk(0, 0, 1, 0, 4'hE, 4'h0, 4'h0, 4'h0, 4'h0, 32'hFFFF_FFF8);
    r4  = mk(1, 0, 0, 0, 4'hE, 4'hC, 4'h0, 4'h1, 4'h0, 32'h4);
    r5  = mk(0, 0, 0, 0, 4'hE, 4'h4, 4'h1, 4'h2, 4'h3, 32'h0);
    r6  = mk(1, 1, 0, 0, 4'hE, 4'hC, 4'h2, 4'h1, 4'h3, 32'h0);
    r7  = mk(0, 0, 0, 1, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0);
    r8  = mk(0, 0, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 32'h40);
    r9  = mk(0, 0, 0, 0, 4'hE, 4'hD, 4'h1, 4'h0, 4'h0, IMM_V9);
    r10 = mk(1, 1, 0, 0, 4'hE, 4'hC, 4'h1, 4'h2, 4'h0, 32'hFFF);

    // reset state
    repeat (2) @(negedge clk);
    check1("rst_out_valid", 64'(out_valid), 64'd0);
    check1("rst_in_ready", 64'(in_ready), 64'd1);
    check1("rst_fields", 64'(got_rec()), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // streaming decode, latency 1 into empty buffer
    out_ready = 1'b1;
    send(V1, r1);
    check1("latency1_out_valid", 64'(out_valid), 64'd1);
    send(V2, r2);
    send(V3, r3);
    send(V4, r4);
    send(V9, r9);
    send(V10, r10);
    send(V8, r8);
    drain();

    // stall: two absorbed, third held until consumer resumes
    out_ready = 1'b0;
    fork
      begin
        send(V5, r5);
        send(V6, r6);
        send(V7, r7);
      end
      begin
        repeat (4) @(negedge clk);
        check1("stall_in_ready", 64'(in_ready), 64'd0);
        check1("stall_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // flush with both entries full and an instruction offered
    out_ready = 1'b0;
    send(V1, r1);
    send(V2, r2);
    check1("full_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1;
    instr    = V7;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    q.delete();
    check1("flush_out_valid", 64'(out_valid), 64'd0);
    check1("flush_in_ready", 64'(in_ready), 64'd1);

    // flush overrides an accept into an empty buffer
    in_valid = 1'b1;
    instr    = V3;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check1("flush_accept_out_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;

    // asynchronous reset mid-stream with both entries full
    out_ready = 1'b0;
    send(V4, r4);
    send(V5, r5);
    #2;
    rst = 1'b0;
    #1;
    check1("midrst_out_valid", 64'(out_valid), 64'd0);
    check1("midrst_in_ready", 64'(in_ready), 64'd1);
    check1("midrst_fields", 64'(got_rec()), 64'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(V6, r6);
    drain();

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
